wb_resp_regfile: RTL
====================

# wb_resp_regfile

Wishbone-style responder (slave) that terminates the bus driven by the wb agent/initiator. It holds a word-addressed register file of `DEPTH_P` entries. It services single read and write cycles with a programmable number of wait states, and acknowledges each accepted cycle with a one-cycle `ack`. It is both the DUT-side endpoint for wb agent stimulus and the reusable control/status register bank for ProyI datapath blocks.

## Interface
Parameters:
- `DATA_SZ_P`, 32: data width in bits.
- `ADDR_SZ_P`, 10: address width in bits (word address).
- `DEPTH_P`, 256: number of implemented registers; must satisfy `DEPTH_P <= 2**ADDR_SZ_P`.
- `WAIT_STATES_P`, 1: extra cycles between accepting a request and `ack`; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cyc`  in  1  bus cycle in progress.
- `stb`  in  1  request strobe.
- `cmd`  in  1  1 = write, 0 = read.
- `addr`  in  `ADDR_SZ_P`  word address.
- `wdata`  in  `DATA_SZ_P`  write data.
- `rdata`  out  `DATA_SZ_P`  read data, valid when `ack`=1 on a read.
- `ack`  out  1  cycle termination, one-cycle pulse.
- `err`  out  1  error termination; present only with `WB_RESP_ERR_EN`.

## Operation
- FSM states: IDLE, WAIT, ACK.
- **IDLE:** when `cyc & stb` = 1, latch `cmd`, `addr` and `wdata`, and load the wait counter with `WAIT_STATES_P`.
  - Go to WAIT if `WAIT_STATES_P` > 0, otherwise go to ACK.
- **WAIT:** the counter decrements each cycle; on reaching 0, go to ACK.
  - If `cyc` = 0 in any WAIT cycle, abort: return to IDLE, no register update, no `ack`.
- **ACK:** `ack` (or `err`) = 1 for exactly one cycle, then IDLE unconditionally.
- **Write:** the register is updated on the same clock edge that drives `ack` high; `rdata` is unchanged by writes.
- **Read:** `rdata` is loaded from the register array on the edge that drives `ack` high and holds its value until the next read ack or `reset`.
- **Out-of-range** (`addr >= DEPTH_P`): writes are discarded, reads return all zeros.
- Request inputs are sampled only in IDLE; changes during WAIT or ACK are ignored.
- **Reset:** FSM goes to IDLE, the counter clears, and all registers are cleared to 0.
  - `ack`=0, `err`=0 and `rdata`=0 in the cycle after `reset` is sampled high.
  - A reset asserted mid-cycle aborts that cycle with no ack and no write.

## Timing
- A request is sampled at edge N (state IDLE); `ack` is high during cycle N+1+`WAIT_STATES_P`.
- Minimum spacing between acks is 2 cycles, because ACK always returns to IDLE. An initiator holding `stb` high after `ack` therefore starts a new cycle that is accepted in the IDLE cycle.
- Throughput: one transfer per `WAIT_STATES_P`+2 cycles.
- `ack` and `err` are never high in the same cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro `WB_RESP_ERR_EN`.
- **Defined:**
  - The `err` port exists.
  - An out-of-range access terminates with `err`=1 and `ack`=0 in the ACK cycle.
  - Writes are discarded and `rdata` is unchanged.
- **Undefined:**
  - There is no `err` port.
  - An out-of-range access terminates normally with `ack`=1.
  - A read returns 0; a write is discarded.

## Test plan
- **Reset and write/read back:** after `reset`, write 0xDEADBEEF to addr 5, then read addr 5.
  - `rdata`=0xDEADBEEF with `ack` at cycle N+2 (`WAIT_STATES_P`=1).
  - A read of addr 6 returns 0.
- **Wait-state sweep:** run with `WAIT_STATES_P` = 0, 1, 3.
  - Ack latency is 1, 2 and 4 cycles respectively.
  - `ack` pulses exactly one cycle per transfer.
- **Back-to-back:** `stb` held high for 4 writes to addrs 0..3 (values 1..4), then read back.
  - Acks are spaced exactly `WAIT_STATES_P`+2 apart.
  - Read data is 1, 2, 3, 4.
- **Abort:** drop `cyc` in WAIT during a write of 0x55 to addr 7.
  - No `ack` is produced.
  - A later read of addr 7 returns its prior value of 0.
- **Out-of-range:** write 0x12345678 to addr `DEPTH_P` (256), then read it back.
  - With `WB_RESP_ERR_EN`: `err`=1 and `ack`=0 for both accesses.
  - Without it: `ack`=1 and `rdata`=0.
  - In both cases registers 0..255 are unchanged.
- **Reset mid-cycle:** assert `reset` during WAIT of a write of 0xA5 to addr 2.
  - `ack` stays 0 and the FSM returns to IDLE.
  - Addr 2 reads 0 afterwards.

Source files
------------

// File: rtl/wb_resp_regfile_if.sv
// Wishbone-style request/response bundle between an initiator and the
// wb_resp_regfile responder.
//   cyc   : bus cycle in progress          (master -> slave)
//   stb   : request strobe                 (master -> slave)
//   cmd   : 1 = write, 0 = read            (master -> slave)
//   addr  : word address                   (master -> slave)
//   wdata : write data                     (master -> slave)
//   rdata : read data, valid with ack      (slave -> master)
//   ack   : normal termination pulse       (slave -> master)
//   err   : error termination pulse, only with WB_RESP_ERR_EN (slave -> master)
interface wb_resp_regfile_if #(
  parameter int unsigned DATA_SZ_P = 32,
  parameter int unsigned ADDR_SZ_P = 10
);
  logic                 cyc;
  logic                 stb;
  logic                 cmd;
  logic [ADDR_SZ_P-1:0] addr;
  logic [DATA_SZ_P-1:0] wdata;
  logic [DATA_SZ_P-1:0] rdata;
  logic                 ack;
`ifdef WB_RESP_ERR_EN
  logic                 err;

  modport master (output cyc, stb, cmd, addr, wdata, input rdata, ack, err);
  modport slave  (input cyc, stb, cmd, addr, wdata, output rdata, ack, err);
`else
  modport master (output cyc, stb, cmd, addr, wdata, input rdata, ack);
  modport slave  (input cyc, stb, cmd, addr, wdata, output rdata, ack);
`endif
endinterface

// File: rtl/wb_resp_regfile.sv
// Wishbone-style responder terminating single read/write cycles on a
// word-addressed register file, with a fixed number of wait states.
// Optional macro WB_RESP_ERR_EN: out-of-range accesses end with err instead
// of ack.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : wb_resp_regfile_if.slave (cyc, stb, cmd, addr, wdata in;
//           rdata, ack [, err] out, all registered)
module wb_resp_regfile #(
  parameter int unsigned DATA_SZ_P     = 32,
  parameter int unsigned ADDR_SZ_P     = 10,
  parameter int unsigned DEPTH_P       = 256,
  parameter int unsigned WAIT_STATES_P = 1
) (
  input  logic              clk,
  input  logic              reset,
  wb_resp_regfile_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 cmd_q;
  logic [ADDR_SZ_P-1:0] addr_q;
  logic [DATA_SZ_P-1:0] wdata_q;
  logic [DATA_SZ_P-1:0] regs [DEPTH_P];
  logic [DATA_SZ_P-1:0] rdata_q;
  logic                 ack_q;
  logic                 err_q;

  logic                 req_cmd;
  logic [ADDR_SZ_P-1:0] req_addr;
  logic [DATA_SZ_P-1:0] req_wdata;
  logic [IDX_W-1:0]     req_idx;
  logic                 in_range;
  logic                 go_ack;

  // Effective request: live inputs in IDLE (zero-wait case completes on the
  // accepting edge), latched copy otherwise.
  always_comb begin
    req_cmd   = cmd_q;
    req_addr  = addr_q;
    req_wdata = wdata_q;
    if (state == ST_IDLE) begin
      req_cmd   = bus.cmd;
      req_addr  = bus.addr;
      req_wdata = bus.wdata;
    end
    req_idx  = req_addr[IDX_W-1:0];
    in_range = 32'(req_addr) < DEPTH_P;
  end

  // Edge that moves the FSM into ACK: this is where ack rises and the
  // register file is read or written.
  always_comb begin
    go_ack = 1'b0;
    case (state)
      ST_IDLE: go_ack = bus.cyc && bus.stb && (WAIT_STATES_P == 0);
      ST_WAIT: go_ack = bus.cyc && (cnt <= CNT_W'(1));
      default: go_ack = 1'b0;
    endcase
  end

  // FSM, register file and registered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      regs    <= '{default: '0};
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.cyc && bus.stb) begin
            cmd_q   <= bus.cmd;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt     <= CNT_W'(WAIT_STATES_P);
            state   <= (WAIT_STATES_P == 0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.cyc) begin
            // Initiator abandoned the cycle: no update, no termination.
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
              state <= ST_ACK;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (go_ack) begin
        if (in_range) begin
          ack_q <= 1'b1;
          if (req_cmd) begin
            regs[req_idx] <= req_wdata;
          end else begin
            rdata_q <= regs[req_idx];
          end
        end else begin
`ifdef WB_RESP_ERR_EN
          err_q <= 1'b1;
`else
          ack_q <= 1'b1;
          if (!req_cmd) begin
            rdata_q <= '0;
          end
`endif
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
`ifdef WB_RESP_ERR_EN
  assign bus.err   = err_q;
`else
  // err_q stays at its reset value when error termination is disabled.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
